uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Hardware UART receiver for the icestick core. It replaces software polling of the RX pin.
- It samples the asynchronous serial line in the clk_core domain, deserialises 8N1 frames and holds each byte in a one-deep holding register.
- The CPU reads the byte through an input port and acknowledges it with a one-cycle read strobe.
- Status flags report data-ready, overrun and framing error.

Parameters:
- CLKS_PER_BIT, 417, clk_core cycles per bit time (48 MHz / 115200). Must be >= 8.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter.

Ports:
- clk_core  in  1  core clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial input from the pin; asynchronous, idles high.
- rd  in  1  one-cycle read/acknowledge strobe from the CPU port decode.
- data  out  8  holding register: last accepted byte.
- full  out  1  holding register contains an unread byte.
- overrun  out  1  sticky: a byte completed while full=1.
- frame_err  out  1  sticky: stop bit sampled low.

Behaviour:
- Reset values (asynchronous, resetn=0):
  - data=0, full=0, overrun=0, frame_err=0.
  - Synchroniser flops = 1. FSM = IDLE. Counters = 0.
- Input synchronisation:
  - rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s.
  - Pin-to-rx_s latency is 2 cycles.
- Sampling:
  - Each bit value is the majority of rx_s at counts MID-1, MID and MID+1, where MID = CLKS_PER_BIT/2 (integer).
  - Bit period is exactly CLKS_PER_BIT cycles, measured from start-edge detection.
- FSM states and transitions:
  - IDLE: wait for rx_s=0. On it, clear the counter and go to START.
  - START: at the vote point, 0 → go to DATA with bit index 0. 1 → false start, return to IDLE with no flag change.
  - DATA: at each vote point, shift the voted bit in LSB first. After bit index 7, go to STOP.
  - STOP, vote 1: go to IDLE at the vote point, not at the end of the bit. This allows back-to-back frames and tolerates up to about 4% baud mismatch.
  - STOP, vote 0: discard the byte, set frame_err, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err and no further bytes.
- Byte acceptance (cycle after the STOP vote point):
  - full=0: data <= shifted byte, full <= 1.
  - full=1 and rd=0 in that cycle: byte dropped, data unchanged, overrun <= 1.
  - full=1 and rd=1 in the same cycle: rd wins first. data <= new byte, full stays 1, no overrun.
- rd pulse behaviour:
  - Clears full, overrun and frame_err on the next edge, unless the same-cycle acceptance rule above sets full.
  - rd with full=0 is harmless apart from clearing the sticky flags.
  - rd has no effect on the receive FSM.
- Flag timing: data, full and the flags are registered. Visible 1 cycle after the deciding edge.
- Reset mid-frame: all state is lost immediately; the partial byte is discarded.
  - After release, the FSM is in IDLE. If rx is low at release, the next falling-to-low is treated as a start.
  - Remaining bits of the interrupted frame may produce a spurious byte or frame_err. This is acceptable and must not hang the FSM.
- Counter arithmetic: CNT_W bits, wraps to 0 at CLKS_PER_BIT-1. No other wrap-around is permitted.

Test Plan:
- Send 0xA5 at 417 cycles/bit, 8N1 → full rises within 9.5 bit times (+3 cycles) of the start edge. data=0xA5, overrun=0, frame_err=0. rd pulse → full=0 next cycle.
- 100-cycle low glitch on an idle line → no change to any output; FSM back in IDLE before 417 cycles elapse.
- Frame 0x3C with stop bit driven 0, then line held low 5 bit times, then high → frame_err=1, full=0, data unchanged. Subsequent 0x81 frame is received normally.
- Send 0x11 then 0x22 back-to-back with no rd → data=0x11, full=1, overrun=1. Repeat with rd asserted exactly in the acceptance cycle of 0x22 → data=0x22, full=1, overrun=0.
- Continuous stream 0x00..0xFF with bit period 400 and 434 cycles (±4%) → all 256 bytes correct when drained each frame.
- Assert resetn=0 for 3 cycles during bit 4 of a frame → all outputs 0 immediately. After line idles 10 bit times, frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, 3-sample majority vote at mid-bit,
// and a one-deep holding register with sticky overrun and framing-error flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s low (start edge)
// ST_START | timing the start bit, a high vote means a false start
// ST_DATA  | shifting in 8 data bits, LSB first
// ST_STOP  | voting on the stop bit, releases to idle at the vote point
// ST_BREAK | stop bit was low, waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 417,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_core,
  input  logic       resetn,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       full,
  output logic       overrun,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_0   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP_1   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] VOTE_PT  = CNT_W'(CLKS_PER_BIT / 2 + 1);

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       samp_q, samp_d;
  logic [7:0]       shift_q, shift_d;
  logic             accept_q, accept_d;
  logic [7:0]       data_q, data_d;
  logic             full_q, full_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             vote;
  logic             at_vote;

  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign at_vote = (cnt_q == VOTE_PT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    accept_d    = 1'b0;
    data_d      = data_q;
    full_d      = full_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    if (rd) begin
      full_d      = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    // A read in the acceptance cycle frees the register before the new byte lands.
    if (accept_q) begin
      if (!full_q || rd) begin
        data_d = shift_q;
        full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == SAMP_0) samp_d[0] = rx_s_q;
      if (cnt_q == SAMP_1) samp_d[1] = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (at_vote) begin
          if (!vote) begin
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (at_vote) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_vote) begin
          if (vote) begin
            accept_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      samp_q      <= 2'b00;
      shift_q     <= 8'h00;
      accept_q    <= 1'b0;
      data_q      <= 8'h00;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      accept_q    <= accept_d;
      data_q      <= data_d;
      full_q      <= full_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign full      = full_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames driven on rx, expected bytes queued at send
// time and compared when full rises. Bit time is scaled down to keep runtime short.
module tb_uart_rx;

  localparam int P       = 25;               // nominal bit time, cycles
  localparam int P_FAST  = 24;               // -4 %
  localparam int P_SLOW  = 26;               // +4 %
  localparam int VOTE    = P / 2 + 1;
  // pin edge -> start detection is 3 edges, then 9.5 bit times + 3 cycles
  localparam int LAT_MAX = (19 * P) / 2 + 3 + 3;

  logic       clk_core = 1'b0;
  logic       resetn;
  logic       rx;
  logic       rd;
  logic       rd_man = 1'b0;
  logic       rd_drain = 1'b0;
  logic       auto_drain = 1'b0;
  logic [7:0] data;
  logic       full;
  logic       overrun;
  logic       frame_err;

  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  assign rd = rd_man | rd_drain;

  always #5 clk_core = ~clk_core;

  uart_rx #(.CLKS_PER_BIT(P)) dut (
    .clk_core  (clk_core),
    .resetn    (resetn),
    .rx        (rx),
    .rd        (rd),
    .data      (data),
    .full      (full),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  task automatic expect_byte(input string tag);
    logic [7:0] e;
    check_val({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val(tag, 32'(data), 32'(e));
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_bit);
    rx = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(p);
    end
    rx = stop_bit;
    tick(p);
  endtask

  task automatic wait_full(input int limit, output int n);
    n = 0;
    while (!full && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  task automatic pulse_rd();
    rd_man = 1'b1;
    tick(1);
    rd_man = 1'b0;
    tick(1);
  endtask

  task automatic recv(input logic [7:0] b, input string tag);
    int n;
    exp_q.push_back(b);
    fork
      send_frame(b, P, 1'b1);
      wait_full(12 * P, n);
    join
    check_val({tag, "_full"}, 32'(full), 32'd1);
    expect_byte(tag);
  endtask

  initial begin
    repeat (200000) @(posedge clk_core);
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Stream drain: compare and acknowledge every byte as soon as full is seen.
  initial begin
    forever begin
      @(negedge clk_core);
      if (auto_drain && full && !rd_drain) begin
        expect_byte("stream_data");
        rd_drain = 1'b1;
      end else begin
        rd_drain = 1'b0;
      end
    end
  end

  initial begin
    int n;
    resetn = 1'b0;
    rx     = 1'b1;
    tick(3);
    check_val("rst_data", 32'(data), 32'h00);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);
    resetn = 1'b1;
    tick(5);

    // basic byte and latency
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, P, 1'b1);
      wait_full(12 * P, n);
    join_any
    check_val("a5_latency_ok", 32'((n >= 9 * P) && (n <= LAT_MAX)), 32'd1);
    wait fork;
    expect_byte("a5_data");
    check_val("a5_overrun", 32'(overrun), 32'd0);
    check_val("a5_frame_err", 32'(frame_err), 32'd0);
    rd_man = 1'b1;
    tick(1);
    rd_man = 1'b0;
    check_val("a5_full_after_rd", 32'(full), 32'd0);
    tick(2 * P);

    // short glitch is a false start; next frame starts one bit time later
    rx = 1'b0;
    tick(6);
    rx = 1'b1;
    tick(P - 6);
    check_val("glitch_data", 32'(data), 32'hA5);
    check_val("glitch_full", 32'(full), 32'd0);
    check_val("glitch_overrun", 32'(overrun), 32'd0);
    check_val("glitch_frame_err", 32'(frame_err), 32'd0);
    recv(8'h96, "after_glitch");
    pulse_rd();
    tick(P);

    // framing error followed by a held-low line
    send_frame(8'h3C, P, 1'b0);
    tick(5 * P);
    rx = 1'b1;
    tick(P);
    check_val("ferr_frame_err", 32'(frame_err), 32'd1);
    check_val("ferr_full", 32'(full), 32'd0);
    check_val("ferr_data", 32'(data), 32'h96);
    recv(8'h81, "after_break");
    check_val("after_break_ferr_sticky", 32'(frame_err), 32'd1);
    pulse_rd();
    check_val("ferr_cleared", 32'(frame_err), 32'd0);
    tick(P);

    // overrun: second byte dropped
    exp_q.push_back(8'h11);
    send_frame(8'h11, P, 1'b1);
    send_frame(8'h22, P, 1'b1);
    tick(2);
    expect_byte("ovr_data");
    check_val("ovr_full", 32'(full), 32'd1);
    check_val("ovr_overrun", 32'(overrun), 32'd1);
    pulse_rd();
    check_val("ovr_overrun_cleared", 32'(overrun), 32'd0);
    check_val("ovr_full_cleared", 32'(full), 32'd0);
    tick(P);

    // rd in the acceptance cycle of the second byte
    send_frame(8'h11, P, 1'b1);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, P, 1'b1);
      begin
        tick(9 * P + VOTE + 4);
        rd_man = 1'b1;
        tick(1);
        rd_man = 1'b0;
      end
    join
    tick(2);
    expect_byte("same_cycle_data");
    check_val("same_cycle_full", 32'(full), 32'd1);
    check_val("same_cycle_overrun", 32'(overrun), 32'd0);
    pulse_rd();
    tick(P);

    // continuous stream at -4 % then +4 % bit time
    auto_drain = 1'b1;
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), (b < 128) ? P_FAST : P_SLOW, 1'b1);
    end
    tick(2 * P);
    auto_drain = 1'b0;
    tick(2);
    check_val("stream_all_drained", 32'(exp_q.size()), 32'd0);
    check_val("stream_overrun", 32'(overrun), 32'd0);
    check_val("stream_frame_err", 32'(frame_err), 32'd0);

    // load some state, then reset in the middle of a frame
    send_frame(8'h3C, P, 1'b0);
    rx = 1'b1;
    tick(2 * P);
    send_frame(8'hC3, P, 1'b1);
    tick(P);
    fork
      send_frame(8'h5A, P, 1'b1);
      begin
        tick(4 * P + P / 2);
        resetn = 1'b0;
        #1;
        check_val("midrst_data", 32'(data), 32'h00);
        check_val("midrst_full", 32'(full), 32'd0);
        check_val("midrst_overrun", 32'(overrun), 32'd0);
        check_val("midrst_frame_err", 32'(frame_err), 32'd0);
        tick(3);
        resetn = 1'b1;
      end
    join
    rx = 1'b1;
    tick(10 * P);
    pulse_rd();
    recv(8'h5A, "post_rst");
    check_val("post_rst_overrun", 32'(overrun), 32'd0);
    check_val("post_rst_frame_err", 32'(frame_err), 32'd0);
    pulse_rd();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
